// File: rtl/sub_n128_cc8_pkg.sv
// Shared arithmetic package: default operand width, words per operation and
// the derived word-index width used by the multi-cycle sum/difference blocks.
package sub_n128_cc8_pkg;

    localparam int PKG_N  = 128;
    localparam int PKG_CC = 8;
    localparam int PKG_W  = PKG_N / PKG_CC;

    // A single-word configuration still needs a one-bit index register.
    localparam int PKG_IDX_W = (PKG_CC > 1) ? $clog2(PKG_CC) : 1;

endpackage

// File: rtl/sub_n128_cc8_sub_word.sv
// One word of a multi-word subtraction: {cout, c} = a + ~b + cin.
// Purely combinational; cout is the inverted borrow.
module sub_word #(
    parameter int W = sub_n128_cc8_pkg::PKG_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] c_o,
    output logic         cout_o
);

    logic [W:0] sum;

    assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, cin_i};
    assign c_o    = sum[W-1:0];
    assign cout_o = sum[W];

endmodule

// File: rtl/sub_n128_cc8.sv
// Word-serial N-bit unsigned subtractor: one W-bit word per valid cycle,
// least-significant first, with registered less-than / equal flags per operation.
module sub_n128_cc8
    import sub_n128_cc8_pkg::*;
#(
    parameter int N  = PKG_N,
    parameter int CC = PKG_CC,
    parameter int W  = N / CC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic         last,
    output logic         done,
    output logic         lt,
    output logic         eq
);

    localparam int IDX_W = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CC - 1);

    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             acc_q;
    logic             done_q;
    logic             lt_q;
    logic             eq_q;

    logic             first_word;
    logic             last_word;
    logic             cin;
    logic             cout;
    logic             c_nz;
    logic             acc_d;

    assign first_word = (idx_q == '0);
    assign last_word  = (idx_q == IDX_LAST);
    assign cin        = first_word ? 1'b1 : carry_q;

    sub_word #(.W(W)) u_sub_word (
        .a_i    (a),
        .b_i    (b),
        .cin_i  (cin),
        .c_o    (c),
        .cout_o (cout)
    );

    // Word 0 starts a fresh accumulation, so any stale value is ignored there.
    assign c_nz  = |c;
    assign acc_d = first_word ? c_nz : (acc_q | c_nz);

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_valid) begin
                carry_q <= cout;
                acc_q   <= acc_d;
                if (last_word) begin
                    idx_q  <= '0;
                    lt_q   <= ~cout;
                    eq_q   <= ~acc_d;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign last = in_valid & last_word;
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_sub_n128_cc8.sv
// Bench for sub_n128_cc8: directed and random 128-bit subtractions checked
// against whole-operand arithmetic (A-B, A<B, A==B) computed in the bench.
module tb_sub_n128_cc8;

    localparam int N  = 128;
    localparam int CC = 8;
    localparam int W  = N / CC;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         last;
    logic         done;
    logic         lt;
    logic         eq;

    int n_chk  = 0;
    int n_fail = 0;

    logic ref_lt;
    logic ref_eq;

    sub_n128_cc8 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .last     (last),
        .done     (done),
        .lt       (lt),
        .eq       (eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] v;
        for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Runs one full operation; gap_at >= 0 inserts 3 idle cycles after that word.
    task automatic run_op(input string name, input logic [N-1:0] A, input logic [N-1:0] B,
                          input int gap_at);
        logic [N-1:0] diff;
        logic [N-1:0] mask;
        logic         bin;
        logic [W-1:0] ew;
        diff   = A - B;
        ref_lt = (A < B);
        ref_eq = (A == B);
        for (int i = 0; i < CC; i++) begin
            in_valid = 1'b1;
            a = A[i*W +: W];
            b = B[i*W +: W];
            #1;
            chk({name, " c"}, 32'(c), 32'(diff[i*W +: W]));
            chk({name, " last"}, 32'(last), 32'(i == CC - 1));
            @(posedge clk);
            #1;
            if (i < CC - 1) begin
                chk({name, " done_mid"}, 32'(done), 32'd0);
            end else begin
                chk({name, " done"}, 32'(done), 32'd1);
                chk({name, " lt"}, 32'(lt), 32'(ref_lt));
                chk({name, " eq"}, 32'(eq), 32'(ref_eq));
            end
            if (i == gap_at) begin
                mask = (N'(1) << (W * (i + 1))) - N'(1);
                bin  = ((A & mask) < (B & mask));
                for (int g = 0; g < 3; g++) begin
                    in_valid = 1'b0;
                    a = W'($urandom);
                    b = W'($urandom);
                    ew = a - b - W'(bin);
                    #1;
                    chk({name, " gap_c"}, 32'(c), 32'(ew));
                    chk({name, " gap_last"}, 32'(last), 32'd0);
                    @(posedge clk);
                    #1;
                    chk({name, " gap_done"}, 32'(done), 32'd0);
                end
            end
        end
    endtask

    task automatic idle_cycle(input string name);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        @(posedge clk);
        #1;
        chk({name, " idle_done"}, 32'(done), 32'd0);
        chk({name, " hold_lt"}, 32'(lt), 32'(ref_lt));
        chk({name, " hold_eq"}, 32'(eq), 32'(ref_eq));
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N-1:0] pat;

        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset done", 32'(done), 32'd0);
        chk("reset lt", 32'(lt), 32'd0);
        chk("reset eq", 32'(eq), 32'd0);
        chk("reset last", 32'(last), 32'd0);
        rst = 1'b1;

        run_op("five_minus_three", N'(5), N'(3), -1);
        idle_cycle("after_53");
        run_op("zero_minus_one", N'(0), N'(1), -1);
        pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run_op("equal", pat, pat, -1);
        idle_cycle("after_eq");
        run_op("ripple", N'(32'h0001_0000), N'(1), -1);

        ra = rand_n();
        rb = rand_n();
        run_op("nogap", ra, rb, -1);
        run_op("gap", ra, rb, 3);
        idle_cycle("after_gap");

        for (int k = 0; k < 6; k++) begin
            ra = rand_n();
            rb = (k == 2) ? ra : rand_n();
            if (k == 4) rb = ra + N'(1);
            run_op("random", ra, rb, (k == 5) ? 0 : -1);
        end
        idle_cycle("after_random");

        // Abort a partially accepted operation with reset.
        run_op("zero_minus_one_b", N'(0), N'(1), -1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            chk("abort done_mid", 32'(done), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort rst done", 32'(done), 32'd0);
        chk("abort rst lt", 32'(lt), 32'd0);
        chk("abort rst eq", 32'(eq), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort no_done", 32'(done), 32'd0);
        end
        run_op("after_abort_53", N'(5), N'(3), -1);
        idle_cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
